uart_image_loader: RTL and testbench
====================================

UART_IMAGE_LOADER -- requirements
Module: uart_image_loader

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 28, image height/width in pixels.
REQ-002 SHALL have parameter PIXEL_DEPTH, default 8, bits per pixel; fixed at 8 because one UART byte carries one pixel.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit; minimum 4.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 SHALL have port consume  input  1  downstream pulse: image taken.
REQ-008 SHALL have port image  output  IMAGE_SIZE*IMAGE_SIZE*PIXEL_DEPTH  flat row-major image buffer.
REQ-009 SHALL have port label  output  4  expected class of the buffered image.
REQ-010 SHALL have port image_valid  output  1  image and label complete and stable.
REQ-011 SHALL have port frame_err  output  1  sticky error flag.
REQ-012 SHALL have port byte_count  output  10  pixels received in the current frame.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-014 Bit receiver SHALL use states IDLE, START, DATA, STOP; a falling edge in IDLE enters START.
REQ-015 START SHALL sample at CLKS_PER_BIT/2 cycles; a high sample is a false start and returns to IDLE with no byte.
REQ-016 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from the start midpoint, LSB first.
REQ-017 STOP SHALL sample one bit; high emits a one-cycle byte strobe; low sets frame_err, drops the byte, and forces the frame FSM to HUNT.
REQ-018 Frame FSM SHALL use states HUNT, LABEL, PIXELS, HOLD.
REQ-019 In HUNT, SHALL discard bytes other than 0xA5; 0xA5 enters LABEL.
REQ-020 In LABEL, byte <= 9 SHALL load label[3:0] and enter PIXELS with byte_count=0.
REQ-021 In LABEL, byte > 9 SHALL set frame_err and return to HUNT.
REQ-022 In PIXELS, pixel n (0-based) SHALL be written to image[n*8+7 -: 8], then byte_count SHALL increment.
REQ-023 After pixel IMAGE_SIZE*IMAGE_SIZE-1, SHALL enter HOLD and assert image_valid on the cycle after that byte strobe.
REQ-024 In HOLD, image, label and byte_count SHALL stay stable; received bytes SHALL be ignored without error.
REQ-025 consume high in HOLD SHALL deassert image_valid the next cycle and enter HUNT; image SHALL keep its contents.
REQ-026 consume outside HOLD SHALL be ignored.
REQ-027 consume in the same cycle as a byte strobe in HOLD SHALL take effect, and the byte SHALL be dropped.
REQ-028 frame_err SHALL clear only on rst.
REQ-029 Bit-level reception SHALL continue independently of the frame state.

Reset
REQ-030 On rst, image, label, byte_count, image_valid and frame_err SHALL be 0.
REQ-031 On rst, both FSMs SHALL enter IDLE/HUNT and the synchronizer SHALL be set high.
REQ-032 rst mid-byte or mid-frame SHALL abort it with no partial image_valid.

Configuration
REQ-033 With UART_LOADER_CHECKSUM_EN defined, one byte SHALL follow the last pixel, equal to (label + sum of pixels) mod 256.
REQ-034 With UART_LOADER_CHECKSUM_EN, image_valid SHALL assert the cycle after the checksum strobe on a match.
REQ-035 With UART_LOADER_CHECKSUM_EN, a checksum mismatch SHALL set frame_err and return to HUNT.
REQ-036 Without UART_LOADER_CHECKSUM_EN, a frame SHALL end at the last pixel per REQ-023.

Verification
REQ-037 Bench SHALL run with CLKS_PER_BIT=4, IMAGE_SIZE=28; send 0xA5, 0x07, pixels n%256 -> image_valid=1, label=7, image[15:8]=0x01, image[6271:6264]=0x0F, frame_err=0.
REQ-038 Bench SHALL send 0x00, 0x3C, then a valid frame with label 2 -> the leading bytes are ignored, label=2, image_valid=1.
REQ-039 Bench SHALL send 0xA5, 0x0C -> frame_err=1, no image_valid; a following valid frame -> image_valid=1, frame_err stays 1.
REQ-040 Bench SHALL send a byte with stop bit forced low during PIXELS -> frame_err=1, FSM in HUNT, no image_valid.
REQ-041 Bench SHALL hold image_valid, send 3 extra bytes, then pulse consume -> image unchanged, image_valid=0 next cycle.
REQ-042 Bench SHALL assert rst after 100 pixels, then send a full frame -> byte_count=0 after rst, and only the new frame produces image_valid.

Source files
------------

// File: rtl/uart_image_loader.sv
// UART 8N1 receiver feeding a framed image loader: 0xA5, label (0-9), IMAGE_SIZE^2 pixels.
// Defining UART_LOADER_CHECKSUM_EN appends a (label + pixel sum) mod 256 byte to each frame.
module uart_image_loader #(
  parameter int IMAGE_SIZE   = 28,
  parameter int PIXEL_DEPTH  = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rx,
  input  logic                                      consume,
  output logic [IMAGE_SIZE*IMAGE_SIZE*PIXEL_DEPTH-1:0] image,
  output logic [3:0]                                label,
  output logic                                      image_valid,
  output logic                                      frame_err,
  output logic [9:0]                                byte_count
);

  localparam int NPIX  = IMAGE_SIZE * IMAGE_SIZE;
  localparam int IMG_W = NPIX * PIXEL_DEPTH;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [9:0]    LAST_PIX = 10'(NPIX - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {FR_HUNT, FR_LABEL, FR_PIXELS, FR_CSUM, FR_HOLD} fr_state_t;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_stb, stop_err;

  fr_state_t        fr_state_q, fr_state_d;
  logic [IMG_W-1:0] image_q;
  logic [3:0]       label_q;
  logic [9:0]       byte_count_q;
  logic             frame_err_q;
  logic             last_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  // Start bit is checked at its midpoint; every later sample is one full bit after that.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_stb = 1'b0;
    stop_err = 1'b0;
    if (rx_state_q == RX_STOP && cnt_q == FULL_M1) begin
      byte_stb = rx_sync_q;
      stop_err = !rx_sync_q;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (byte_stb) begin
      if (fr_state_q == FR_LABEL)       csum_q <= shift_q;
      else if (fr_state_q == FR_PIXELS) csum_q <= csum_q + shift_q;
    end
  end
`endif

  assign last_pix = (byte_count_q == LAST_PIX);

  always_ff @(posedge clk) begin
    if (rst) fr_state_q <= FR_HUNT;
    else     fr_state_q <= fr_state_d;
  end

  // A framing error abandons the frame wherever it is; consume wins over a byte arriving in HOLD.
  always_comb begin
    fr_state_d = fr_state_q;
    if (stop_err) begin
      fr_state_d = FR_HUNT;
    end else begin
      case (fr_state_q)
        FR_HUNT:   if (byte_stb && shift_q == 8'hA5) fr_state_d = FR_LABEL;
        FR_LABEL:  if (byte_stb) fr_state_d = (shift_q <= 8'd9) ? FR_PIXELS : FR_HUNT;
        FR_PIXELS: begin
          if (byte_stb && last_pix) begin
`ifdef UART_LOADER_CHECKSUM_EN
            fr_state_d = FR_CSUM;
`else
            fr_state_d = FR_HOLD;
`endif
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        FR_CSUM:   if (byte_stb) fr_state_d = (shift_q == csum_q) ? FR_HOLD : FR_HUNT;
`endif
        FR_HOLD:   if (consume) fr_state_d = FR_HUNT;
        default:   fr_state_d = FR_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      image_q      <= '0;
      label_q      <= '0;
      byte_count_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      if (stop_err) frame_err_q <= 1'b1;
      if (byte_stb) begin
        case (fr_state_q)
          FR_LABEL: begin
            if (shift_q <= 8'd9) begin
              label_q      <= shift_q[3:0];
              byte_count_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          FR_PIXELS: begin
            image_q[int'(byte_count_q)*PIXEL_DEPTH +: PIXEL_DEPTH] <= shift_q;
            byte_count_q <= byte_count_q + 10'd1;
          end
`ifdef UART_LOADER_CHECKSUM_EN
          FR_CSUM: if (shift_q != csum_q) frame_err_q <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    image       = image_q;
    label       = label_q;
    byte_count  = byte_count_q;
    frame_err   = frame_err_q;
    image_valid = (fr_state_q == FR_HOLD);
  end

endmodule

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader: serial stimulus on rx, scoreboard of expected frames checked on image_valid.
module tb_uart_image_loader;

  localparam int IMAGE_SIZE = 28;
  localparam int CPB        = 4;
  localparam int NPIX       = IMAGE_SIZE * IMAGE_SIZE;
  localparam int IMG_W      = NPIX * 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx;
  logic             consume;
  logic [IMG_W-1:0] image;
  logic [3:0]       label;
  logic             image_valid;
  logic             frame_err;
  logic [9:0]       byte_count;

  typedef struct {
    logic [3:0]       lbl;
    logic             err;
    logic [IMG_W-1:0] img;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_image_loader #(
    .IMAGE_SIZE  (IMAGE_SIZE),
    .PIXEL_DEPTH (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .consume    (consume),
    .image      (image),
    .label      (label),
    .image_valid(image_valid),
    .frame_err  (frame_err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int n);
    if (pat == 0) return 8'(n % 256);
    return 8'((3 * n + 1) % 256);
  endfunction

  function automatic logic [IMG_W-1:0] build_img(input int pat);
    logic [IMG_W-1:0] v;
    v = '0;
    for (int n = 0; n < NPIX; n++) v[n*8 +: 8] = pix(pat, n);
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Only complete frames are expected to raise image_valid, so only those enter the scoreboard.
  task automatic send_frame(input logic [7:0] lbl, input int pat, input int npix, input logic exp_err);
    exp_t e;
    if (npix == NPIX) begin
      e.lbl = lbl[3:0];
      e.err = exp_err;
      e.img = build_img(pat);
      sb_q.push_back(e);
    end
    send_byte(8'hA5, 1'b1);
    send_byte(lbl, 1'b1);
    for (int n = 0; n < npix; n++) send_byte(pix(pat, n), 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (image_valid && !prev_v) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: image_valid=1 with no frame outstanding, expected 0");
        end else begin
          e = sb_q.pop_front();
          check("mon_label", label, e.lbl);
          check("mon_frame_err", frame_err, e.err);
          check("mon_byte_count", byte_count, NPIX);
          check("mon_image", image === e.img, 1);
        end
      end
      prev_v = image_valid;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [IMG_W-1:0] ref0;
    ref0    = build_img(0);
    rst     = 1'b1;
    rx      = 1'b1;
    consume = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", image_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_label", label, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a frame
    send_frame(8'd5, 0, 100, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_byte_count", byte_count, 100);
    check("mid_valid", image_valid, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst2_byte_count", byte_count, 0);
    check("rst2_valid", image_valid, 0);
    check("rst2_image_zero", image == '0, 1);
    repeat (4) @(negedge clk);

    // Clean frame, label 7, pixels n%256
    send_frame(8'd7, 0, NPIX, 1'b0);
    repeat (4) @(negedge clk);
    check("f1_valid", image_valid, 1);
    check("f1_label", label, 7);
    check("f1_pix1", image[15:8], 8'h01);
    check("f1_pix783", image[6271:6264], 8'h0F);
    check("f1_frame_err", frame_err, 0);

    // Bytes in HOLD are ignored, then consume releases the image
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_valid", image_valid, 1);
    check("hold_byte_count", byte_count, NPIX);
    check("hold_image", image === ref0, 1);
    check("hold_frame_err", frame_err, 0);
    consume = 1'b1;
    @(negedge clk);
    consume = 1'b0;
    check("consume_valid", image_valid, 0);
    check("consume_image_kept", image === ref0, 1);

    // Out-of-range label
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0C, 1'b1);
    repeat (4) @(negedge clk);
    check("badlbl_frame_err", frame_err, 1);
    check("badlbl_valid", image_valid, 0);
    check("badlbl_label", label, 7);

    // Framing error during pixels, then a byte that would count if still in PIXELS
    send_frame(8'd3, 0, 5, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    check("stoperr_frame_err", frame_err, 1);
    check("stoperr_valid", image_valid, 0);
    check("stoperr_byte_count", byte_count, 5);
    send_byte(8'h09, 1'b1);
    repeat (4) @(negedge clk);
    check("hunt_byte_count", byte_count, 5);

    // Leading junk then a valid frame, label 2, pixels (3n+1)%256; error flag stays sticky
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_frame(8'd2, 1, NPIX, 1'b1);
    repeat (4) @(negedge clk);
    check("f2_valid", image_valid, 1);
    check("f2_label", label, 2);
    check("f2_pix1", image[15:8], 8'h04);
    check("f2_pix783", image[6271:6264], 8'h2E);
    check("f2_frame_err", frame_err, 1);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
